// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and hazard_ctrl (slave).
// Carries the hazard-detection inputs and the per-stage enable/flush controls.
interface hazard_ctrl_if;
  logic       idex_memread;
  logic [4:0] idex_wn;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       exmem_branch;
  logic       exmem_zero;
  logic       mem_busy;
  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;

  modport master (
    output idex_memread, idex_wn, ifid_rs, ifid_rt, exmem_branch, exmem_zero, mem_busy,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush
  );

  modport slave (
    input  idex_memread, idex_wn, ifid_rs, ifid_rt, exmem_branch, exmem_zero, mem_busy,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencer: load-use stalls, MEM-resolved branch flushes, memory wait states.
// Define HAZARD_STATS_EN to build the stall/flush statistics counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned STAT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  hazard_ctrl_if.slave      hz,
  output logic [1:0]        state_o,
  output logic              mem_timeout_o,
  output logic [STAT_W-1:0] stall_cnt_o,
  output logic [STAT_W-1:0] flush_cnt_o
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StLuStall = 2'd1;
  localparam logic [1:0] StBrFlush = 2'd2;
  localparam logic [1:0] StMemWait = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            timeout_q, timeout_d;
  logic            lu, bt;
  logic            pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic            ifid_flush, idex_flush, exmem_flush;

  assign lu = hz.idex_memread && (hz.idex_wn != 5'd0) &&
              ((hz.idex_wn == hz.ifid_rs) || (hz.idex_wn == hz.ifid_rt));
  assign bt = hz.exmem_branch && hz.exmem_zero;

  // Priority: reset > mem_busy > taken branch > load-use.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    state_d     = StRun;
    wait_cnt_d  = '0;
    timeout_d   = timeout_q;
    if (rst_i) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
      {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
      timeout_d = 1'b0;
    end else if (hz.mem_busy) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
      state_d    = StMemWait;
      wait_cnt_d = (wait_cnt_q == {TO_W{1'b1}}) ? wait_cnt_q : wait_cnt_q + 1'b1;
      if (wait_cnt_d == TO_W'(MEM_TIMEOUT)) begin
        timeout_d = 1'b1;
      end
    end else if (bt && (state_q != StBrFlush)) begin
      {ifid_flush, idex_flush, exmem_flush} = 3'b111;
      state_d = StBrFlush;
    end else if (lu && (state_q != StBrFlush) && (state_q != StLuStall)) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      state_d    = StLuStall;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign hz.pc_en       = pc_en;
  assign hz.ifid_en     = ifid_en;
  assign hz.idex_en     = idex_en;
  assign hz.exmem_en    = exmem_en;
  assign hz.memwb_en    = memwb_en;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_flush = exmem_flush;
  assign state_o        = state_q;
  assign mem_timeout_o  = timeout_q;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, flush_cnt_q;

  // A taken branch is the only non-reset cause of an EX_MEM flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en && (stall_cnt_q != {STAT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (exmem_flush && (flush_cnt_q != {STAT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes hand-computed expectations, monitor compares.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl #(
    .MEM_TIMEOUT(3),
    .TO_W       (8),
    .STAT_W     (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .hz           (hif),
    .state_o      (state),
    .mem_timeout_o(mem_timeout),
    .stall_cnt_o  (stall_cnt),
    .flush_cnt_o  (flush_cnt)
  );

  // {pc, ifid, idex, exmem, memwb enables, ifid/idex/exmem flushes}
  localparam logic [7:0] RUNV = 8'b11111_000;
  localparam logic [7:0] LUV  = 8'b00111_010;
  localparam logic [7:0] BRV  = 8'b11111_111;
  localparam logic [7:0] FRZ  = 8'b00000_000;
  localparam logic [7:0] RSTV = 8'b00000_111;

  typedef struct {
    string       name;
    logic [42:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [15:0] stv(input int v);
`ifdef HAZARD_STATS_EN
    return 16'(v);
`else
    return 16'(v) & 16'h0;
`endif
  endfunction

  task automatic step(input string name, input logic r, input logic mr, input logic [4:0] wn,
                      input logic [4:0] rs, input logic [4:0] rt, input logic br,
                      input logic z, input logic busy, input logic [7:0] ctrl,
                      input logic [1:0] st, input logic to, input int sc, input int fc);
    exp_t e;
    @(negedge clk);
    rst              = r;
    hif.idex_memread = mr;
    hif.idex_wn      = wn;
    hif.ifid_rs      = rs;
    hif.ifid_rt      = rt;
    hif.exmem_branch = br;
    hif.exmem_zero   = z;
    hif.mem_busy     = busy;
    e.name = name;
    e.exp  = {ctrl, st, to, stv(sc), stv(fc)};
    sb.push_back(e);
  endtask

  // Monitor: outputs are Mealy, so compare mid-cycle after the driver updates inputs.
  initial begin
    exp_t        e;
    logic [42:0] act;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
               hif.ifid_flush, hif.idex_flush, hif.exmem_flush,
               state, mem_timeout, stall_cnt, flush_cnt};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got ctrl=%b st=%0d to=%b sc=%0d fc=%0d, want ctrl=%b st=%0d to=%b sc=%0d fc=%0d",
                   e.name, act[42:35], act[34:33], act[32], act[31:16], act[15:0],
                   e.exp[42:35], e.exp[34:33], e.exp[32], e.exp[31:16], e.exp[15:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    hif.idex_memread = 1'b0;
    hif.idex_wn      = 5'd0;
    hif.ifid_rs      = 5'd0;
    hif.ifid_rt      = 5'd0;
    hif.exmem_branch = 1'b0;
    hif.exmem_zero   = 1'b0;
    hif.mem_busy     = 1'b0;
    //     name          r  mr wn  rs  rt  br z  bsy ctrl  st to sc fc
    step("reset0",       1, 0, 0,  0,  0,  0, 0, 0, RSTV, 0, 0, 0, 0);
    step("reset1",       1, 0, 0,  0,  0,  0, 0, 0, RSTV, 0, 0, 0, 0);
    step("reset2",       1, 0, 0,  0,  0,  0, 0, 0, RSTV, 0, 0, 0, 0);
    step("run_first",    0, 0, 0,  0,  0,  0, 0, 0, RUNV, 0, 0, 0, 0);
    step("lu_rt",        0, 1, 8,  0,  8,  0, 0, 0, LUV,  0, 0, 0, 0);
    step("lu_rt_held",   0, 1, 8,  0,  8,  0, 0, 0, RUNV, 1, 0, 1, 0);
    step("lu_rt_after",  0, 0, 0,  0,  0,  0, 0, 0, RUNV, 0, 0, 1, 0);
    step("wn_zero",      0, 1, 0,  0,  0,  0, 0, 0, RUNV, 0, 0, 1, 0);
    step("lu_rs",        0, 1, 5,  5,  3,  0, 0, 0, LUV,  0, 0, 1, 0);
    step("lu_rs_after",  0, 0, 0,  0,  0,  0, 0, 0, RUNV, 1, 0, 2, 0);
    step("br_not_taken", 0, 0, 0,  0,  0,  1, 0, 0, RUNV, 0, 0, 2, 0);
    step("bt",           0, 0, 0,  0,  0,  1, 1, 0, BRV,  0, 0, 2, 0);
    step("bt_ignored",   0, 0, 0,  0,  0,  1, 1, 0, RUNV, 2, 0, 2, 1);
    step("bt_after",     0, 0, 0,  0,  0,  0, 0, 0, RUNV, 0, 0, 2, 1);
    step("bt_lu",        0, 1, 8,  0,  8,  1, 1, 0, BRV,  0, 0, 2, 1);
    step("lu_in_brf",    0, 1, 8,  0,  8,  0, 0, 0, RUNV, 2, 0, 2, 2);
    step("brf_after",    0, 0, 0,  0,  0,  0, 0, 0, RUNV, 0, 0, 2, 2);
    step("busy1",        0, 1, 8,  0,  8,  1, 1, 1, FRZ,  0, 0, 2, 2);
    step("busy2",        0, 1, 8,  0,  8,  1, 1, 1, FRZ,  3, 0, 3, 2);
    step("busy3",        0, 1, 8,  0,  8,  1, 1, 1, FRZ,  3, 0, 4, 2);
    step("busy4_to",     0, 1, 8,  0,  8,  1, 1, 1, FRZ,  3, 1, 5, 2);
    step("busy_drop_bt", 0, 1, 8,  0,  8,  1, 1, 0, BRV,  3, 1, 6, 2);
    step("post_wait_lu", 0, 1, 8,  0,  8,  0, 0, 0, RUNV, 2, 1, 6, 3);
    step("to_sticky",    0, 0, 0,  0,  0,  0, 0, 0, RUNV, 0, 1, 6, 3);
    step("lu_pre_rst",   0, 1, 9,  9,  0,  0, 0, 0, LUV,  0, 1, 6, 3);
    step("rst_in_lu",    1, 0, 0,  0,  0,  0, 0, 0, RSTV, 1, 1, 7, 3);
    step("after_rst_lu", 0, 0, 0,  0,  0,  0, 0, 0, RUNV, 0, 0, 0, 0);
    step("busy_pre_rst", 0, 0, 0,  0,  0,  0, 0, 1, FRZ,  0, 0, 0, 0);
    step("rst_in_wait",  1, 0, 0,  0,  0,  0, 0, 1, RSTV, 3, 0, 1, 0);
    step("after_rst_mw", 0, 0, 0,  0,  0,  0, 0, 0, RUNV, 0, 0, 0, 0);
    step("cnt_clr1",     0, 0, 0,  0,  0,  0, 0, 1, FRZ,  0, 0, 0, 0);
    step("cnt_clr2",     0, 0, 0,  0,  0,  0, 0, 1, FRZ,  3, 0, 1, 0);
    step("cnt_clr3",     0, 0, 0,  0,  0,  0, 0, 1, FRZ,  3, 0, 2, 0);
    step("wait_release", 0, 0, 0,  0,  0,  0, 0, 0, RUNV, 3, 1, 3, 0);
    step("final_run",    0, 0, 0,  0,  0,  0, 0, 0, RUNV, 0, 1, 3, 0);
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
